// File: rtl/mul_pkg.sv
// Shared encodings for the multiply controller: op codes, operand signedness
// codes, FSM states and the result-selection helper.
package mul_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULH   = 2'd1,
    OP_MULHSU = 2'd2,
    OP_MULHU  = 2'd3
  } op_t;

  // m_signed codes: bit 1 = rs1 signed, bit 0 = rs2 signed
  localparam logic [1:0] SGN_SS = 2'b11;
  localparam logic [1:0] SGN_SU = 2'b10;
  localparam logic [1:0] SGN_UU = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [1:0] sgn_code(input logic [1:0] op);
    case (op)
      OP_MULHSU: return SGN_SU;
      OP_MULHU:  return SGN_UU;
      default:   return SGN_SS;
    endcase
  endfunction

  // MULW returns the low word sign-extended; MUL the low half; MULH* the high half.
  function automatic logic [63:0] sel_result(input logic [1:0] op, input logic w,
                                             input logic [63:0] hi, input logic [63:0] lo);
    if (w) return {{32{lo[31]}}, lo[31:0]};
    else if (op == OP_MUL) return lo;
    else return hi;
  endfunction

endpackage

// File: rtl/mul_result_cache.sv
// One-entry cache of the last full-width product, keyed by operands and
// signedness. A MUL lookup ignores signedness because the low half is identical.
module mul_result_cache
  import mul_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] lk_src1,
  input  logic [63:0] lk_src2,
  input  logic [1:0]  lk_op,
  input  logic        lk_w,
  output logic        hit,
  output logic [63:0] hit_hi,
  output logic [63:0] hit_lo,
  input  logic        wr_en,
  input  logic [63:0] wr_src1,
  input  logic [63:0] wr_src2,
  input  logic [1:0]  wr_sgn,
  input  logic [63:0] wr_hi,
  input  logic [63:0] wr_lo
);

  logic        vld;
  logic [63:0] c_src1;
  logic [63:0] c_src2;
  logic [1:0]  c_sgn;
  logic [63:0] c_hi;
  logic [63:0] c_lo;

  assign hit = vld && !lk_w && (lk_src1 == c_src1) && (lk_src2 == c_src2) &&
               ((lk_op == OP_MUL) || (sgn_code(lk_op) == c_sgn));
  assign hit_hi = c_hi;
  assign hit_lo = c_lo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld    <= 1'b0;
      c_src1 <= '0;
      c_src2 <= '0;
      c_sgn  <= '0;
      c_hi   <= '0;
      c_lo   <= '0;
    end else if (wr_en) begin
      vld    <= 1'b1;
      c_src1 <= wr_src1;
      c_src2 <= wr_src2;
      c_sgn  <= wr_sgn;
      c_hi   <= wr_hi;
      c_lo   <= wr_lo;
    end
  end

endmodule

// File: rtl/mul_ctrl.sv
// Multiply controller: accepts one op at a time, serves repeats from a
// one-entry result cache, otherwise issues to an external multiplier.
module mul_ctrl
  import mul_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic        in_w,
  input  logic [63:0] in_src1,
  input  logic [63:0] in_src2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_flush,
  output logic        m_mulw,
  output logic [1:0]  m_signed,
  output logic [63:0] m_a,
  output logic [63:0] m_b,
  input  logic        m_out_valid,
  input  logic [63:0] m_hi,
  input  logic [63:0] m_lo,
  output state_t      dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid and its payload stay stable until that edge.

  state_t      state;
  logic [1:0]  op_q;
  logic        w_q;
  logic [63:0] src1_q;
  logic [63:0] src2_q;
  logic [1:0]  sgn_q;
  logic        cache_hit;
  logic [63:0] hit_hi;
  logic [63:0] hit_lo;
  logic        cache_wr;

  assign m_a       = src1_q;
  assign m_b       = src2_q;
  assign m_signed  = sgn_q;
  assign m_mulw    = w_q;
  assign m_flush   = flush & rst;
  assign dbg_state = state;
  // A flushed completion must not pollute the cache; W results never enter it.
  assign cache_wr  = (state == S_BUSY) && m_out_valid && !flush && !w_q;

  mul_result_cache u_cache (
    .clk     (clk),
    .rst     (rst),
    .lk_src1 (in_src1),
    .lk_src2 (in_src2),
    .lk_op   (in_op),
    .lk_w    (in_w),
    .hit     (cache_hit),
    .hit_hi  (hit_hi),
    .hit_lo  (hit_lo),
    .wr_en   (cache_wr),
    .wr_src1 (src1_q),
    .wr_src2 (src2_q),
    .wr_sgn  (sgn_q),
    .wr_hi   (m_hi),
    .wr_lo   (m_lo)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      m_valid   <= 1'b0;
      op_q      <= '0;
      w_q       <= 1'b0;
      src1_q    <= '0;
      src2_q    <= '0;
      sgn_q     <= '0;
    end else if (flush) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      m_valid   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            op_q     <= in_op;
            w_q      <= in_w;
            src1_q   <= in_src1;
            src2_q   <= in_src2;
            sgn_q    <= sgn_code(in_op);
            in_ready <= 1'b0;
            if (cache_hit) begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              out_data  <= sel_result(in_op, in_w, hit_hi, hit_lo);
            end else begin
              state   <= S_ISSUE;
              m_valid <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (m_out_valid) begin
            out_data  <= sel_result(op_q, w_q, m_hi, m_lo);
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl with a behavioural multiplier responder and a
// queue-based scoreboard on the result port.
module tb_mul_ctrl;
  import mul_pkg::*;

  localparam int MUL_LAT = 3;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic        in_w;
  logic [63:0] in_src1;
  logic [63:0] in_src2;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_flush;
  logic        m_mulw;
  logic [1:0]  m_signed;
  logic [63:0] m_a;
  logic [63:0] m_b;
  logic        m_out_valid;
  logic [63:0] m_hi;
  logic [63:0] m_lo;
  state_t      dbg_state;

  logic        resp_ready;
  logic        resp_ignore_flush;
  logic [63:0] exp_q[$];
  int          n_tests;
  int          n_fail;

  assign m_ready = resp_ready;

  mul_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_w        (in_w),
    .in_src1     (in_src1),
    .in_src2     (in_src2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_flush     (m_flush),
    .m_mulw      (m_mulw),
    .m_signed    (m_signed),
    .m_a         (m_a),
    .m_b         (m_b),
    .m_out_valid (m_out_valid),
    .m_hi        (m_hi),
    .m_lo        (m_lo),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, required 0x%h", name, act, req);
    end
  endtask

  // ---------------- multiplier responder ----------------
  function automatic logic [127:0] mul_model(input logic [63:0] a, input logic [63:0] b,
                                             input logic [1:0] sgn);
    logic [127:0] ae;
    logic [127:0] be;
    ae = sgn[1] ? {{64{a[63]}}, a} : {64'd0, a};
    be = sgn[0] ? {{64{b[63]}}, b} : {64'd0, b};
    return ae * be;
  endfunction

  initial begin
    logic [127:0] p;
    bit cancel;
    m_out_valid = 1'b0;
    m_hi = '0;
    m_lo = '0;
    forever begin
      @(negedge clk);
      if (rst && m_valid && m_ready) begin
        p = mul_model(m_a, m_b, m_signed);
        cancel = 0;
        repeat (MUL_LAT) begin
          @(negedge clk);
          if ((m_flush && !resp_ignore_flush) || !rst) cancel = 1;
        end
        if (!cancel) begin
          @(posedge clk); #1;
          m_out_valid = 1'b1;
          m_hi = p[127:64];
          m_lo = p[63:0];
          @(posedge clk); #1;
          m_out_valid = 1'b0;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got result 0x%h, required no result", out_data);
        end else begin
          chk("out_data", out_data, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic [1:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_v, input bit exp_hit,
                        input logic [1:0] exp_sgn, input int hold);
    bit got;
    bit seen_m;
    int cyc;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_op    = op;
    in_w     = w;
    in_src1  = a;
    in_src2  = b;
    if (hold > 0) out_ready = 1'b0;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
    end
    chk("accept", 64'(got), 64'd1);
    if (got) exp_q.push_back(exp_v);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!got) begin
      out_ready = 1'b1;
      return;
    end
    got = 0;
    seen_m = 0;
    cyc = 0;
    while (!got && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (m_valid && !seen_m) begin
        seen_m = 1;
        chk("m_signed", 64'(m_signed), 64'(exp_sgn));
        chk("m_mulw", 64'(m_mulw), 64'(w));
      end
      got = out_valid;
    end
    chk("out_valid_seen", 64'(got), 64'd1);
    if (exp_hit) begin
      chk("hit_latency", 64'(cyc), 64'd1);
      chk("hit_no_m_valid", 64'(seen_m), 64'd0);
    end else begin
      chk("miss_m_valid", 64'(seen_m), 64'd1);
    end
    for (int i = 0; i < hold; i++) begin
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_out_data", out_data, exp_v);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
    end
    got = 1;
    for (int i = 0; i < 20 && got; i++) begin
      @(negedge clk);
      got = out_valid;
    end
    chk("out_valid_drop", 64'(got), 64'd0);
    chk("ready_after_done", 64'(in_ready), 64'd1);
  endtask

  // Raises a request and waits for acceptance without scoreboarding it.
  task automatic raw_req(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    bit got;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_op    = op;
    in_w     = 1'b0;
    in_src1  = a;
    in_src2  = b;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
    end
    chk("raw_accept", 64'(got), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit any;
    bit late;
    bit got;
    n_tests = 0;
    n_fail = 0;
    rst = 1'b0;
    flush = 1'b1;
    in_valid = 1'b0;
    in_op = 2'd0;
    in_w = 1'b0;
    in_src1 = '0;
    in_src2 = '0;
    out_ready = 1'b1;
    resp_ready = 1'b1;
    resp_ignore_flush = 1'b0;

    // reset state
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_flush", 64'(m_flush), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(S_IDLE));
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("in_ready_before_clock", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("in_ready_after_clock", 64'(in_ready), 64'd1);

    // MULH miss then MUL hit on (-1, 2)
    do_req(OP_MULH,  1'b0, ONES, 64'd2, ONES,                   1'b0, SGN_SS, 0);
    do_req(OP_MUL,   1'b0, ONES, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, SGN_SS, 0);
    // MULHU differs in signedness: miss, replaces entry
    do_req(OP_MULHU, 1'b0, ONES, 64'd2, 64'd1,                  1'b0, SGN_UU, 0);
    do_req(OP_MULHU, 1'b0, ONES, 64'd2, 64'd1,                  1'b1, SGN_UU, 0);
    do_req(OP_MUL,   1'b0, ONES, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, SGN_SS, 0);
    // MULW: sign-extended low word, cache unchanged
    do_req(OP_MUL,   1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, SGN_SS, 0);
    do_req(OP_MULHU, 1'b0, ONES, 64'd2, 64'd1,                  1'b1, SGN_UU, 0);
    do_req(OP_MUL,   1'b0, 64'h7FFF_FFFF, 64'd2, 64'h0000_0000_FFFF_FFFE, 1'b0, SGN_SS, 0);
    // (-1, -1) under each signedness
    do_req(OP_MULHSU, 1'b0, ONES, ONES, ONES,  1'b0, SGN_SU, 0);
    do_req(OP_MULH,   1'b0, ONES, ONES, 64'd0, 1'b0, SGN_SS, 0);
    do_req(OP_MUL,    1'b0, ONES, ONES, 64'd1, 1'b1, SGN_SS, 0);

    // flush while BUSY, with a late completion pulse from the multiplier
    resp_ignore_flush = 1'b1;
    raw_req(OP_MULHU, 64'd3, 64'd5);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (dbg_state == S_BUSY);
    end
    chk("reach_busy", 64'(got), 64'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("m_flush_pulse", 64'(m_flush), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("m_flush_low", 64'(m_flush), 64'd0);
    chk("flush_state", 64'(dbg_state), 64'(S_IDLE));
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    any = 0;
    late = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) any = 1;
      if (m_out_valid) late = 1;
      @(negedge clk);
    end
    chk("flush_no_out_valid", 64'(any), 64'd0);
    chk("late_pulse_seen", 64'(late), 64'd1);
    resp_ignore_flush = 1'b0;
    do_req(OP_MULH, 1'b0, ONES, ONES, 64'd0, 1'b1, SGN_SS, 0);

    // in_valid coinciding with flush is ignored
    @(posedge clk); #1;
    in_valid = 1'b1;
    flush = 1'b1;
    in_op = OP_MUL;
    in_w = 1'b0;
    in_src1 = ONES;
    in_src2 = ONES;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b0;
    any = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid || m_valid) any = 1;
    end
    chk("flush_ignores_in", 64'(any), 64'd0);
    chk("flush_in_state", 64'(dbg_state), 64'(S_IDLE));

    do_req(OP_MUL, 1'b0, 64'd3, 64'd5, 64'd15, 1'b0, SGN_SS, 0);
    // out_ready held low in DONE
    do_req(OP_MUL, 1'b0, 64'd3, 64'd5, 64'd15, 1'b1, SGN_SS, 5);

    // reset while ISSUE
    resp_ready = 1'b0;
    raw_req(OP_MUL, 64'd7, 64'd9);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = m_valid;
    end
    chk("issue_m_valid", 64'(got), 64'd1);
    chk("issue_state", 64'(dbg_state), 64'(S_ISSUE));
    #2;
    rst = 1'b0;
    #1;
    chk("async_m_valid", 64'(m_valid), 64'd0);
    chk("async_in_ready", 64'(in_ready), 64'd0);
    chk("async_state", 64'(dbg_state), 64'(S_IDLE));
    chk("async_m_a", m_a, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    resp_ready = 1'b1;
    do_req(OP_MUL,   1'b0, 64'd3, 64'd5, 64'd15, 1'b0, SGN_SS, 0);
    do_req(OP_MULHU, 1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, SGN_UU, 0);

    // ---------------- report ----------------
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
